// File: rtl/stream_rx_fifo.sv
// Consumer-side elastic buffer for a valid/ready stream: show-ahead pop port,
// occupancy and almost-full reporting, flush, accepted-beat counter, sticky underflow.
module stream_rx_fifo #(
    parameter int W         = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [W-1:0]           s_data,
    output logic                   rd_valid,
    output logic [W-1:0]           rd_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
    output logic [15:0]            beat_cnt,
    output logic                   underflow,
    input  logic                   err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   beat_cnt_q, beat_cnt_d;
    logic          underflow_q, underflow_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic do_pop;
    logic pop_empty;

    // The extra pointer bit distinguishes full from empty when the index bits match.
    always_comb begin
        full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty       = (wr_ptr_q == rd_ptr_q);
        s_ready     = !full && !flush && !rst;
        rd_valid    = !empty;
        rd_data     = mem_q[rd_ptr_q[AW-1:0]];
        level       = wr_ptr_q - rd_ptr_q;
        almost_full = (level >= PW'(AF_THRESH));
        beat_cnt    = beat_cnt_q;
        underflow   = underflow_q;
        push        = s_valid && s_ready;
        do_pop      = pop && rd_valid && !flush;
        pop_empty   = pop && !rd_valid && !flush;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        underflow_d = underflow_q;
        mem_d       = mem_q;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = s_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
            beat_cnt_d              = beat_cnt_q + 16'd1;
        end

        // Flush never coincides with a push because s_ready is held low during it.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (err_clr) begin
            underflow_d = 1'b0;
        end
        if (pop_empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_stream_rx_fifo.sv
// Scoreboard bench for stream_rx_fifo: accepted beats are queued as expected data
// and a negedge monitor compares each popped head entry against the queue.
module tb_stream_rx_fifo;
    localparam int W         = 32;
    localparam int DEPTH     = 8;
    localparam int AF_THRESH = 6;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          pop;
    logic          flush;
    logic [3:0]    level;
    logic          almost_full;
    logic [15:0]   beat_cnt;
    logic          underflow;
    logic          err_clr;

    int            errors = 0;
    int            checks = 0;
    logic [W-1:0]  expq[$];
    logic [15:0]   expBeats;
    logic          pendValid = 1'b0;
    logic [W-1:0]  pendData = '0;
    logic [W-1:0]  expData;
    logic          prodDone;
    int            maxLevel;

    stream_rx_fifo #(
        .W(W),
        .DEPTH(DEPTH),
        .AF_THRESH(AF_THRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .pop(pop),
        .flush(flush),
        .level(level),
        .almost_full(almost_full),
        .beat_cnt(beat_cnt),
        .underflow(underflow),
        .err_clr(err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic void noteHandshake(input logic [W-1:0] d);
        expq.push_back(d);
        expBeats = expBeats + 16'd1;
    endfunction

    // Offers one beat and holds it until accepted (bounded); returns at posedge+1.
    task automatic applyStimulus(input logic [W-1:0] d);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("push_accepted", 32'(s_ready), 32'd1);
        if (s_ready) noteHandshake(d);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic resetDut();
        s_valid = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
        #1 rst  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        expq.delete();
        expBeats = 16'd0;
    endtask

    // Monitor: producer-stability check and scoreboard comparison of popped data.
    always @(negedge clk) begin
        if (!rst && pendValid && !(s_valid === 1'b1 && s_data === pendData)) begin
            errors++;
            $display("[TB] FAIL protocol_stable: s_valid=%0b s_data=0x%0h, required 1 / 0x%0h",
                     s_valid, s_data, pendData);
        end
        pendValid = !rst && s_valid && !s_ready;
        pendData  = s_data;
        if (!rst && pop && rd_valid && !flush) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_underrun: got rd_data 0x%0h, expected no data", rd_data);
            end else begin
                expData = expq.pop_front();
                if (rd_data !== expData) begin
                    errors++;
                    $display("[TB] FAIL rd_data: got 0x%0h, expected 0x%0h", rd_data, expData);
                end
            end
        end
    end

    initial begin
        rst      = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        pop      = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
        expBeats = 16'd0;
        prodDone = 1'b0;
        maxLevel = 0;

        #1 rst = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("reset_level", 32'(level), 32'd0);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'd0);
        checkOutput("reset_almost_full", 32'(almost_full), 32'd0);
        checkOutput("reset_beat_cnt", 32'(beat_cnt), 32'd0);
        checkOutput("reset_underflow", 32'(underflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        checkOutput("idle_s_ready", 32'(s_ready), 32'd1);

        $display("[TB] fill and drain");
        for (int i = 0; i < 8; i++) begin
            checkOutput("fill_almost_full", 32'(almost_full), 32'(i >= 6));
            applyStimulus(W'(i));
        end
        checkOutput("fill_level", 32'(level), 32'd8);
        checkOutput("fill_s_ready", 32'(s_ready), 32'd0);
        checkOutput("fill_almost_full_8", 32'(almost_full), 32'd1);
        checkOutput("fill_head", rd_data, 32'h0);
        checkOutput("fill_beat_cnt", 32'(beat_cnt), 32'd8);
        pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("drain_level", 32'(level), 32'(8 - i));
            cycle();
        end
        pop = 1'b0;
        checkOutput("drain_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("drain_level_end", 32'(level), 32'd0);
        checkOutput("drain_underflow", 32'(underflow), 32'd0);

        $display("[TB] full with simultaneous pop");
        for (int i = 0; i < 8; i++) applyStimulus(W'(32'h10 + i));
        s_valid = 1'b1;
        s_data  = 32'h18;
        pop     = 1'b1;
        @(negedge clk);
        checkOutput("full_pop_s_ready", 32'(s_ready), 32'd0);
        cycle();
        pop = 1'b0;
        checkOutput("full_pop_level", 32'(level), 32'd7);
        @(negedge clk);
        checkOutput("after_pop_s_ready", 32'(s_ready), 32'd1);
        if (s_ready) noteHandshake(32'h18);
        cycle();
        s_valid = 1'b0;
        checkOutput("after_push_level", 32'(level), 32'd8);
        checkOutput("after_push_beat_cnt", 32'(beat_cnt), 32'd17);
        pop = 1'b1;
        repeat (8) cycle();
        pop = 1'b0;
        checkOutput("full_drain_level", 32'(level), 32'd0);

        $display("[TB] streaming with stalls");
        resetDut();
        prodDone = 1'b0;
        maxLevel = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    if ($urandom_range(0, 3) == 0) cycle();
                    applyStimulus(W'($urandom));
                end
                prodDone = 1'b1;
            end
            begin
                int n;
                n = 0;
                while ((!prodDone || rd_valid) && n < 3000) begin
                    pop = ($urandom_range(0, 1) == 1) && rd_valid;
                    @(negedge clk);
                    if (int'(level) > maxLevel) maxLevel = int'(level);
                    cycle();
                    n++;
                end
                pop = 1'b0;
            end
        join
        checkOutput("stream_beat_cnt", 32'(beat_cnt), 32'd100);
        checkOutput("stream_max_level_ok", 32'(maxLevel <= 8), 32'd1);
        checkOutput("stream_underflow", 32'(underflow), 32'd0);
        checkOutput("stream_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("stream_queue_empty", 32'(expq.size()), 32'd0);

        $display("[TB] underflow");
        pop = 1'b1;
        cycle();
        pop = 1'b0;
        checkOutput("uf_set", 32'(underflow), 32'd1);
        checkOutput("uf_level", 32'(level), 32'd0);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        checkOutput("uf_clear", 32'(underflow), 32'd0);
        pop     = 1'b1;
        err_clr = 1'b1;
        cycle();
        pop     = 1'b0;
        err_clr = 1'b0;
        checkOutput("uf_set_wins", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        checkOutput("uf_clear2", 32'(underflow), 32'd0);
        s_valid = 1'b1;
        s_data  = 32'h33;
        pop     = 1'b1;
        @(negedge clk);
        checkOutput("empty_pp_s_ready", 32'(s_ready), 32'd1);
        if (s_ready) noteHandshake(32'h33);
        cycle();
        s_valid = 1'b0;
        pop     = 1'b0;
        checkOutput("empty_pp_level", 32'(level), 32'd1);
        checkOutput("empty_pp_underflow", 32'(underflow), 32'd1);
        checkOutput("empty_pp_rd_data", rd_data, 32'h33);
        pop     = 1'b1;
        err_clr = 1'b1;
        cycle();
        pop     = 1'b0;
        err_clr = 1'b0;
        checkOutput("empty_pp_cleared", 32'(underflow), 32'd0);
        checkOutput("empty_pp_drained", 32'(level), 32'd0);

        $display("[TB] flush");
        for (int i = 0; i < 5; i++) applyStimulus(W'(32'h40 + i));
        checkOutput("flush_pre_level", 32'(level), 32'd5);
        checkOutput("flush_pre_beat_cnt", 32'(beat_cnt), 32'd106);
        s_valid = 1'b1;
        s_data  = 32'h55;
        pop     = 1'b1;
        flush   = 1'b1;
        @(negedge clk);
        checkOutput("flush_s_ready", 32'(s_ready), 32'd0);
        cycle();
        flush = 1'b0;
        pop   = 1'b0;
        expq.delete();
        checkOutput("flush_level", 32'(level), 32'd0);
        checkOutput("flush_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("flush_underflow", 32'(underflow), 32'd0);
        checkOutput("flush_beat_cnt", 32'(beat_cnt), 32'd106);
        @(negedge clk);
        checkOutput("post_flush_s_ready", 32'(s_ready), 32'd1);
        if (s_ready) noteHandshake(32'h55);
        cycle();
        s_valid = 1'b0;
        checkOutput("post_flush_rd_data", rd_data, 32'h55);
        checkOutput("post_flush_beat_cnt", 32'(beat_cnt), 32'd107);
        pop = 1'b1;
        cycle();
        pop   = 1'b1;
        flush = 1'b1;
        cycle();
        pop   = 1'b0;
        flush = 1'b0;
        checkOutput("flush_empty_pop_underflow", 32'(underflow), 32'd0);

        $display("[TB] reset mid-stream");
        resetDut();
        applyStimulus(32'h1);
        applyStimulus(32'h2);
        applyStimulus(32'h3);
        checkOutput("mid_pre_beat_cnt", 32'(beat_cnt), 32'd3);
        checkOutput("mid_pre_level", 32'(level), 32'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_level", 32'(level), 32'd0);
        checkOutput("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("mid_rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
        expq.delete();
        expBeats = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        cycle();
        applyStimulus(32'hA5);
        checkOutput("post_rst_rd_valid", 32'(rd_valid), 32'd1);
        checkOutput("post_rst_rd_data", rd_data, 32'hA5);
        checkOutput("post_rst_level", 32'(level), 32'd1);
        checkOutput("post_rst_beat_cnt", 32'(beat_cnt), 32'd1);
        pop = 1'b1;
        cycle();
        pop = 1'b0;
        checkOutput("post_rst_drained", 32'(level), 32'd0);

        checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_rx_fifo.md
Name: stream_rx_fifo

Overview:
- Consumer-side elastic buffer for the team's valid/ready stream: occupies the consumer end of a stream link (drives ready; observes valid/data) and buffers accepted beats in a FIFO.
- The local datapath drains the FIFO through a show-ahead pop port.
- Provides level, almost-full, flush, an accepted-beat counter and a sticky underflow flag.

Parameters:
- W, 32, stream data width in bits (>=1).
- DEPTH, 8, FIFO entries; power of two, >=2.
- AF_THRESH, 6, almost_full asserts when level >= AF_THRESH (1..DEPTH).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  stream valid from producer.
- s_ready  output  1  stream ready to producer.
- s_data  input  W  stream data.
- rd_valid  output  1  FIFO non-empty; rd_data valid.
- rd_data  output  W  head-of-FIFO entry (show-ahead).
- pop  input  1  consume head entry this cycle.
- flush  input  1  synchronous clear of contents.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  level >= AF_THRESH.
- beat_cnt  output  16  count of accepted stream beats, wraps 0xFFFF->0.
- underflow  output  1  sticky: pop seen while rd_valid=0.
- err_clr  input  1  clears underflow.

Behaviour:
- Reset (async assert, sync deassert by the surrounding logic): wr_ptr=rd_ptr=0, level=0, rd_valid=0, s_ready=0 while rst high, almost_full=0, beat_cnt=0, underflow=0. rd_data is don't-care while rd_valid=0.
- Pointers are $clog2(DEPTH)+1 bits with an extra wrap bit.
- full = (wr_ptr[MSB] != rd_ptr[MSB]) && (low bits equal). empty = pointers equal.
- level = wr_ptr - rd_ptr (modulo width).
- s_ready = !full && !flush && !rst. It has no combinational dependence on pop or s_valid. Push when full with simultaneous pop is NOT accepted.
- push = s_valid && s_ready. On push: mem[wr_ptr low bits] <= s_data, wr_ptr++, beat_cnt++.
- Protocol obligations on the producer (bench asserts these): once s_valid=1, s_valid and s_data stay stable until the handshake.
- rd_valid = !empty.
- rd_data = mem[rd_ptr low bits], combinational read of registered storage.
- do_pop = pop && rd_valid, which advances rd_ptr.
- Latency: a beat accepted at edge N is visible on rd_data/rd_valid after edge N (cycle N+1). There is no bypass into an empty FIFO.
- Simultaneous push and pop with 0 < level < DEPTH: both occur, level unchanged.
- Simultaneous push and pop with level=0: only push occurs (rd_valid=0), level becomes 1, underflow sets.
- pop while rd_valid=0: no pointer change, underflow <= 1.
- underflow clears on err_clr. If err_clr and a new underflow occur in the same cycle, set wins.
- flush=1 at an edge: rd_ptr <= wr_ptr (FIFO empty next cycle). s_ready is low that cycle, so no push. A pop in the same cycle is ignored and does not set underflow. beat_cnt is unaffected.
- Wrap-around: pointers roll over naturally. Data order is preserved across any number of wraps.
- beat_cnt wraps silently; there is no saturation.
- Reset mid-operation: all state returns to reset values immediately. Buffered data is discarded.

Test Plan:
- Fill/drain: DEPTH=8. Push 0x0..0x7 with pop=0 -> s_ready drops after the 8th handshake, level=8, almost_full=1 from level 6. Then pop 8 cycles -> rd_data 0x0..0x7 in order, rd_valid=0 after, level=0.
- Full with pop: level=8, s_valid=1, pop=1 same cycle -> no push accepted that cycle, level=7. The next cycle s_ready=1 and the push is accepted.
- Streaming/wrap: 100 beats with continuous s_valid and random pop (50%) plus random producer stalls -> output sequence equals input sequence, beat_cnt=100, level never exceeds 8, no underflow.
- Underflow: pop=1 with FIFO empty -> underflow=1, level stays 0. Assert err_clr for one cycle -> underflow=0. err_clr together with an empty pop -> underflow stays 1.
- Flush: 5 entries buffered, flush=1 with s_valid=1 and pop=1 -> s_ready=0 that cycle, next cycle level=0, rd_valid=0, underflow=0, beat_cnt unchanged.
- Reset mid-stream: 3 entries buffered and beat_cnt=3, assert rst asynchronously between edges -> outputs immediately show level=0, rd_valid=0, s_ready=0, beat_cnt=0. After release, the first push of 0xA5 appears on rd_data the next cycle.
